// File: rtl/abc_stage_pkg.sv
// Shared types and helpers for the a/b/c input conditioning stage.
package abc_stage_pkg;

   typedef enum logic {MODE_MANUAL, MODE_SWEEP} mode_e;

   typedef logic [2:0] abc_t;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One raw async input: 2-flop synchroniser followed by a consecutive-mismatch debouncer.
module debounce_bit
   import abc_stage_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic clean
);

   localparam int CW = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta_q;
   logic          sync_q;
   logic          deb_q;
   logic          deb_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         deb_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         meta_q <= raw;
         sync_q <= meta_q;
         deb_q  <= deb_d;
         cnt_q  <= cnt_d;
      end
   end

   // Any agreeing cycle restarts the count; the last mismatch cycle accepts the new value.
   always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync_q != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d = sync_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign clean = deb_q;

endmodule

// File: rtl/abc_input_conditioner.sv
// Conditions board switches into registered a/b/c, with an automatic sweep of all 8 patterns.
module abc_input_conditioner
   import abc_stage_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int DWELL_CYCLES    = 50000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] sw_in,
   input  logic       mode_sweep,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic [2:0] pattern,
   output logic       update
);

   localparam int DW = cnt_w(DWELL_CYCLES);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

   logic [3:0] raw_w;
   logic [3:0] deb_w;
   abc_t       sw_deb;
   logic       mode_deb;

   assign raw_w = {mode_sweep, sw_in};

   generate
      for (genvar i = 0; i < 4; i++) begin : g_deb
         debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_w[i]),
            .clean (deb_w[i])
         );
      end
   endgenerate

   assign sw_deb   = deb_w[2:0];
   assign mode_deb = deb_w[3];

   mode_e         state_q;
   mode_e         state_d;
   logic [DW-1:0] dwell_q;
   logic [DW-1:0] dwell_d;
   abc_t          pat_q;
   abc_t          pat_d;
   abc_t          abc_q;
   abc_t          abc_d;
   logic          update_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= MODE_MANUAL;
         dwell_q  <= '0;
         pat_q    <= '0;
         abc_q    <= '0;
         update_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         dwell_q  <= dwell_d;
         pat_q    <= pat_d;
         abc_q    <= abc_d;
         update_q <= (abc_d != abc_q);
      end
   end

   // Mode transitions are checked before the dwell terminal count so they win a tie.
   always_comb begin
      state_d = state_q;
      dwell_d = '0;
      pat_d   = '0;
      abc_d   = abc_q;
      case (state_q)
         MODE_MANUAL: begin
            if (mode_deb) begin
               state_d = MODE_SWEEP;
               abc_d   = '0;
            end else begin
               abc_d   = sw_deb;
            end
         end
         MODE_SWEEP: begin
            if (!mode_deb) begin
               state_d = MODE_MANUAL;
               abc_d   = sw_deb;
            end else if (dwell_q == DWELL_LAST) begin
               pat_d   = pat_q + 3'd1;
               abc_d   = pat_d;
            end else begin
               dwell_d = dwell_q + 1'b1;
               pat_d   = pat_q;
               abc_d   = pat_q;
            end
         end
         default: begin
            state_d = MODE_MANUAL;
         end
      endcase
   end

   assign {a, b, c} = abc_q;
   assign pattern   = abc_q;
   assign update    = update_q;

endmodule

// File: tb/tb_abc_input_conditioner.sv
// Bench for abc_input_conditioner: window-based debounce model plus time-based sweep model.
module tb_abc_input_conditioner;

   localparam int D   = 4;
   localparam int DWL = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] sw_in = 3'b000;
   logic       mode_sweep = 1'b0;
   logic       a, b, c, update;
   logic [2:0] pattern;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   abc_input_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .DWELL_CYCLES   (DWL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_in      (sw_in),
      .mode_sweep (mode_sweep),
      .a          (a),
      .b          (b),
      .c          (c),
      .pattern    (pattern),
      .update     (update)
   );

   // Reference model state.
   logic [3:0] hq[$];
   logic [3:0] m_deb;
   logic [2:0] m_abc;
   logic       m_upd;
   bit         m_sweep;
   int         n;
   int         t_start;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      hq.delete();
      for (int i = 0; i < D + 2; i++) hq.push_back(4'b0000);
      m_deb   = 4'b0000;
      m_abc   = 3'b000;
      m_upd   = 1'b0;
      m_sweep = 1'b0;
      n       = 0;
      t_start = 0;
   endtask

   // A debounced bit flips when the D raw samples taken 2..D+1 edges ago all
   // disagree with it; sweep pattern is elapsed edges since entry divided by dwell.
   always @(posedge clk or negedge rst_n) begin
      logic [2:0] nxt;
      bit         all;
      if (!rst_n) begin
         model_clear();
      end else begin
         n++;
         if (!m_deb[3]) begin
            m_sweep = 1'b0;
            nxt     = m_deb[2:0];
         end else if (!m_sweep) begin
            m_sweep = 1'b1;
            t_start = n;
            nxt     = 3'b000;
         end else begin
            nxt = 3'((n - t_start) / DWL);
         end
         m_upd = (nxt != m_abc);
         m_abc = nxt;
         for (int bi = 0; bi < 4; bi++) begin
            all = 1'b1;
            for (int k = 2; k <= D + 1; k++)
               if (hq[hq.size() - k][bi] == m_deb[bi]) all = 1'b0;
            if (all) m_deb[bi] = ~m_deb[bi];
         end
         hq.push_back({mode_sweep, sw_in});
         if (hq.size() > D + 8) void'(hq.pop_front());
      end
   end

   always @(negedge clk) begin
      chk("abc", {29'd0, a, b, c}, {29'd0, m_abc});
      chk("pattern", {29'd0, pattern}, {29'd0, m_abc});
      chk("update", {31'd0, update}, {31'd0, m_upd});
   end

   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic count_pulses(input int cyc, output int np);
      np = 0;
      repeat (cyc) begin
         @(negedge clk);
         if (update === 1'b1) np++;
      end
   endtask

   task automatic wait_abc(input logic [2:0] v, input int lim);
      int i;
      i = 0;
      while ({a, b, c} !== v && i < lim) begin
         @(negedge clk);
         i++;
      end
      checks++;
      if ({a, b, c} !== v) begin
         failures++;
         $display("FAIL wait_abc: got %b expected %b within %0d cycles", {a, b, c}, v, lim);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int np;
      step(3);
      chk("rst_abc", {29'd0, a, b, c}, 32'd0);
      chk("rst_update", {31'd0, update}, 32'd0);
      rst_n = 1'b1;
      step(10);

      // Glitch of 3 cycles on c must be rejected.
      sw_in = 3'b001;
      step(3);
      sw_in = 3'b000;
      count_pulses(15, np);
      chk("glitch_pulses", np, 32'd0);
      chk("glitch_abc", {29'd0, a, b, c}, 32'd0);

      // Manual step 000 -> 101: new value on the 7th rising edge.
      sw_in = 3'b101;
      step(6);
      chk("manual_early", {29'd0, a, b, c}, 32'd0);
      step(1);
      chk("manual_abc", {29'd0, a, b, c}, 32'h5);
      chk("manual_update", {31'd0, update}, 32'd1);
      step(1);
      chk("manual_update_clr", {31'd0, update}, 32'd0);

      // Sweep entry from 101 with sw=111, then 8 steps in 24 cycles.
      sw_in = 3'b111;
      mode_sweep = 1'b1;
      step(6);
      chk("sweep_pre", {29'd0, a, b, c}, 32'h5);
      step(1);
      chk("sweep_entry", {29'd0, a, b, c}, 32'd0);
      chk("sweep_entry_upd", {31'd0, update}, 32'd1);
      count_pulses(24, np);
      chk("sweep_pulses", np, 32'd8);
      chk("sweep_wrap", {29'd0, a, b, c}, 32'd0);

      // Sweep exit while pattern is 110.
      wait_abc(3'b110, 30);
      sw_in = 3'b011;
      mode_sweep = 1'b0;
      step(7);
      chk("exit_abc", {29'd0, a, b, c}, 32'h3);
      chk("exit_update", {31'd0, update}, 32'd1);
      count_pulses(12, np);
      chk("exit_stopped", np, 32'd0);

      // Mode fall coincides with the dwell terminal count at pattern 011.
      sw_in = 3'b110;
      mode_sweep = 1'b1;
      step(12);
      mode_sweep = 1'b0;
      step(6);
      chk("simul_before", {29'd0, a, b, c}, 32'h3);
      step(1);
      chk("simul_abc", {29'd0, a, b, c}, 32'h6);

      // Asynchronous reset mid-sweep at pattern 101.
      sw_in = 3'b000;
      mode_sweep = 1'b1;
      wait_abc(3'b101, 60);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_abc", {29'd0, a, b, c}, 32'd0);
      chk("async_rst_pattern", {29'd0, pattern}, 32'd0);
      chk("async_rst_update", {31'd0, update}, 32'd0);
      sw_in = 3'b010;
      mode_sweep = 1'b0;
      step(3);
      rst_n = 1'b1;
      step(6);
      chk("post_rst_hold", {29'd0, a, b, c}, 32'd0);
      step(1);
      chk("post_rst_abc", {29'd0, a, b, c}, 32'h2);

      // Randomised traffic against the model.
      for (int it = 0; it < 300; it++) begin
         sw_in = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 5) == 0) mode_sweep = ~mode_sweep;
         if ($urandom_range(0, 99) == 0) begin
            rst_n = 1'b0;
            step(2);
            rst_n = 1'b1;
         end
         step($urandom_range(1, 12));
      end
      step(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
